// File: rtl/truth_table_sequencer.sv
// rtl/truth_table_sequencer.sv - exhaustive 3-input truth-table tester for a = b/c equation circuit
module truth_table_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] result,
    output logic [3:0] err_cnt
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("SETTLE_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FINISH} state_t;

    state_t     state, state_n;
    logic [2:0] vec, vec_n;
    logic [3:0] cnt, cnt_n;
    logic [2:0] abc_n;
    logic       busy_n, done_n, pass_n;
    logic [7:0] result_n;
    logic [3:0] err_n;
    logic       golden;

    // Golden compare uses the registered stimulus, which always equals vec while busy
    assign golden = a & (b | c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            vec     <= '0;
            cnt     <= '0;
            {a, b, c} <= 3'b000;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            result  <= '0;
            err_cnt <= '0;
        end else begin
            state   <= state_n;
            vec     <= vec_n;
            cnt     <= cnt_n;
            {a, b, c} <= abc_n;
            busy    <= busy_n;
            done    <= done_n;
            pass    <= pass_n;
            result  <= result_n;
            err_cnt <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        vec_n    = vec;
        cnt_n    = cnt;
        abc_n    = {a, b, c};
        busy_n   = busy;
        done_n   = 1'b0;
        pass_n   = pass;
        result_n = result;
        err_n    = err_cnt;

        if (busy && abort) begin
            // Partial result and err_cnt are deliberately kept for inspection
            state_n = IDLE;
            vec_n   = '0;
            cnt_n   = '0;
            abc_n   = 3'b000;
            busy_n  = 1'b0;
            pass_n  = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state_n  = SETTLE;
                        vec_n    = '0;
                        cnt_n    = RELOAD;
                        abc_n    = 3'b000;
                        busy_n   = 1'b1;
                        pass_n   = 1'b0;
                        result_n = '0;
                        err_n    = '0;
                    end
                end
                SETTLE: begin
                    if (cnt == 4'd0) state_n = SAMPLE;
                    else             cnt_n   = cnt - 4'd1;
                end
                SAMPLE: begin
                    result_n[vec] = y;
                    err_n         = err_cnt + {3'b000, (y != golden)};
                    if (vec == 3'd7) begin
                        state_n = FINISH;
                        abc_n   = 3'b000;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = (err_n == 4'd0);
                    end else begin
                        state_n = SETTLE;
                        vec_n   = vec + 3'd1;
                        abc_n   = vec + 3'd1;
                        cnt_n   = RELOAD;
                    end
                end
                FINISH: begin
                    state_n = IDLE;
                    vec_n   = '0;
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb/tb_truth_table_sequencer.sv - directed self-checking bench for truth_table_sequencer
module tb_truth_table_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, y;
    logic       a, b, c, busy, done, pass;
    logic [7:0] result;
    logic [3:0] err_cnt;

    int   tests = 0;
    int   fails = 0;
    int   y_mode = 0;
    logic y_force = 1'b0;

    truth_table_sequencer #(.SETTLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .y(y),
        .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
        .result(result), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Circuit under control: 0 correct, 1 stuck-0, 2 a&b&c, 3 bench-forced, 4 inverted
    always_comb begin
        y = 1'b0;
        case (y_mode)
            0: y = a & (b | c);
            1: y = 1'b0;
            2: y = a & b & c;
            3: y = y_force;
            4: y = ~(a & (b | c));
            default: y = 1'b0;
        endcase
    end

    function automatic logic gold(input logic [2:0] v);
        return v[2] & (v[1] | v[0]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_watch(input int n, input string tag);
        int seen;
        seen = 0;
        repeat (n) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        chk(tag, seen, 0);
    endtask

    // Start at cycle 0 (edge 0 accepts it); done expected in cycle 41
    task automatic run(input int mode, input int restart_at, input logic [7:0] er,
                       input logic [3:0] ee, input logic ep, input string tag);
        int         bad;
        logic [2:0] ev;
        y_mode = mode;
        bad    = 0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int cy = 1; cy <= 40; cy++) begin
            ev = 3'((cy - 1) / 5);
            if ({a, b, c} !== ev || busy !== 1'b1 || done !== 1'b0) bad++;
            y_force = (cy % 5 == 0) ? gold(ev) : ~gold(ev);
            start   = (cy == restart_at);
            tick();
        end
        start = 1'b0;
        chk({tag, ".seq"},    bad, 0);
        chk({tag, ".done"},   done, 1'b1);
        chk({tag, ".busy"},   busy, 1'b0);
        chk({tag, ".abc"},    {a, b, c}, 3'b000);
        chk({tag, ".result"}, result, er);
        chk({tag, ".err"},    err_cnt, ee);
        chk({tag, ".pass"},   pass, ep);
        tick();
        chk({tag, ".pulse"},  done, 1'b0);
        chk({tag, ".hold"},   {pass, result, err_cnt}, {ep, er, ee});
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        tick(); tick();
        chk("reset.outs", {a, b, c, busy, done, pass}, 6'b0);
        chk("reset.res",  {result, err_cnt}, 12'h000);
        rst_n = 1'b1;
        tick();

        start = 1'b1; abort = 1'b1;
        tick();
        chk("abort_wins", {busy, a, b, c}, 4'b0);
        start = 1'b0; abort = 1'b0;
        tick();

        run(0, 10, 8'hE0, 4'd0, 1'b1, "correct");
        run(1, 0,  8'h00, 4'd3, 1'b0, "stuck0");
        run(2, 0,  8'h80, 4'd2, 1'b0, "and3");
        run(4, 0,  8'h1F, 4'd8, 1'b0, "invert");
        run(3, 0,  8'hE0, 4'd0, 1'b1, "settle_noise");

        // Abort at cycle 20 with inverted circuit: vectors 0..2 already sampled
        y_mode = 4;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (19) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort.busy", {busy, a, b, c, done, pass}, 6'b0);
        chk("abort.part", {result, err_cnt}, {8'h07, 4'd3});
        idle_watch(45, "abort.nodone");
        run(0, 0, 8'hE0, 4'd0, 1'b1, "after_abort");

        // Reset asserted mid-cycle 15 must clear outputs without a clock edge
        y_mode = 0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (14) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid.outs", {a, b, c, busy, done, pass}, 6'b0);
        chk("rst_mid.res",  {result, err_cnt}, 12'h000);
        tick(); tick();
        rst_n = 1'b1;
        idle_watch(45, "rst_mid.nodone");
        run(0, 0, 8'hE0, 4'd0, 1'b1, "after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/truth_table_sequencer.md
TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 4, giving the number of cycles each input vector is held before y is sampled; legal range is 1..15 and 0 SHALL be rejected at elaboration.
REQ-002 Port clk, input, 1 bit: the single clock, rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 Port start, input, 1 bit: request one full exhaustive run.
REQ-005 Port abort, input, 1 bit: synchronous cancel of a run in progress.
REQ-006 Port y, input, 1 bit: output of the equation circuit under control.
REQ-007 Ports a, b, c, outputs, 1 bit each: stimulus driven to the equation circuit inputs.
REQ-008 Port busy, output, 1 bit: high while a run is in progress.
REQ-009 Port done, output, 1 bit: one-cycle pulse at the end of a completed run.
REQ-010 Port pass, output, 1 bit: 1 when the last completed run had zero mismatches.
REQ-011 Port result, output, 8 bits: result[k] holds the y value captured for vector k.
REQ-012 Port err_cnt, output, 4 bits: mismatch count, range 0..8.

Function
REQ-013 The FSM SHALL have the states IDLE, SETTLE, SAMPLE and FINISH.
REQ-014 Vector index vec (3 bits) SHALL map to outputs as a=vec[2], b=vec[1], c=vec[0].
REQ-015 The golden value SHALL be g = a & (b | c), which equals a&b&c | a&b | a&c.
REQ-016 IDLE, start=1 and abort=0 -> SETTLE next cycle, with vec=0, result=0, err_cnt=0, pass=0, busy=1, and the settle counter loaded with SETTLE_CYCLES-1.
REQ-017 SETTLE SHALL decrement the counter each cycle; at 0 the FSM goes to SAMPLE, so SETTLE lasts exactly SETTLE_CYCLES cycles.
REQ-018 SAMPLE (one cycle) SHALL capture y into result[vec] and increment err_cnt if y != g.
REQ-019 On leaving SAMPLE: if vec=7 -> FINISH; otherwise increment vec, reload the counter, and go to SETTLE.
REQ-020 a, b and c SHALL be registered and stable throughout SETTLE and SAMPLE for a given vec, and SHALL be 0 in IDLE and FINISH.
REQ-021 In FINISH (one cycle) the block SHALL set done=1, busy=0 and pass=(err_cnt==0, including the vec-7 sample), then go to IDLE.
REQ-022 Latency: with start accepted at cycle 0, vec k SHALL be sampled at cycle (k+1)*(SETTLE_CYCLES+1), and done SHALL be high at cycle 8*(SETTLE_CYCLES+1)+1 (cycle 41 for the default).
REQ-023 start SHALL be ignored whenever busy=1.
REQ-024 abort=1 while busy SHALL return the FSM to IDLE next cycle with busy=0, a=b=c=0, no done pulse and pass=0; result and err_cnt SHALL hold their partial values.
REQ-025 If abort and start are both high in IDLE, abort SHALL win and the FSM SHALL stay in IDLE.
REQ-026 y SHALL be ignored in every state except SAMPLE.
REQ-027 result, err_cnt and pass SHALL hold their values in IDLE until the next accepted start.
REQ-028 err_cnt SHALL NOT wrap, since its maximum of 8 fits in 4 bits.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, vec=0, counter=0, a=b=c=0, busy=0, done=0, pass=0, result=0 and err_cnt=0.
REQ-030 Reset mid-run SHALL abandon the run with no done pulse; the first start after rst_n deasserts SHALL begin a fresh run from vec 0.

Verification
REQ-031 Correct circuit (y = a&(b|c)), SETTLE_CYCLES=4, start pulse at cycle 0 -> done at cycle 41, result=8'hE0, err_cnt=0, pass=1.
REQ-032 y stuck at 0 -> result=8'h00, err_cnt=3, pass=0.
REQ-033 Faulty y = a&b&c -> result=8'h80, err_cnt=2 (vectors 5 and 6), pass=0.
REQ-034 abort at cycle 20 -> busy=0 and a=b=c=0 at cycle 21, no done pulse; a new start then gives a full correct run as in REQ-031.
REQ-035 start re-pulsed at cycle 10 -> no effect and done still at cycle 41; rst_n low at cycle 15 -> all outputs 0 immediately, and no done pulse follows.
REQ-036 y wrong during SETTLE but correct on every SAMPLE cycle -> err_cnt=0, pass=1.
